// File: rtl/bdy_axis_out_packer_pkg.sv
// Shared definitions for the MDL_BDY output packer.
//   PRM_DAXI : AXIS data width, two RAM coefficients per beat
//   PRM_DRAM : coefficient width of one RAM bank
//   PRM_ADDR : RAM address width, a transfer can be up to 2^PRM_ADDR beats
//   KEEP_ALL : TKEEP value, every byte of every beat is valid
//   state_e  : packer FSM states
package pkg_bdy;

  localparam int unsigned PRM_DRAM = 32;
  localparam int unsigned PRM_DAXI = 2 * PRM_DRAM;
  localparam int unsigned PRM_ADDR = 12;

  localparam logic [PRM_DAXI/8-1:0] KEEP_ALL = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/bdy_axis_out_packer_fifo2.sv
// Two-entry register FIFO carrying a data word plus a last flag.
//   clk_i, rst_ni          : clock, synchronous active-low reset
//   push_i, push_data_i,
//   push_last_i            : write one entry
//   pop_i                  : remove the head entry (ignored when empty)
//   data_o, last_o         : head entry
//   valid_o                : FIFO not empty
//   occ_o                  : number of stored entries (0..2)
// Push and pop in the same cycle leave the occupancy unchanged.
module bdy_out_fifo2 #(
  parameter int unsigned DW = 64
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          push_last_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic          last_o,
  output logic          valid_o,
  output logic [1:0]    occ_o
);

  logic [DW-1:0] data0_q, data0_d, data1_q, data1_d;
  logic          last0_q, last0_d, last1_q, last1_d;
  logic [1:0]    occ_q, occ_d;
  logic          do_pop;

  assign do_pop = pop_i && (occ_q != 2'd0);

  // Slot 0 is always the head; a pop shifts slot 1 forward.
  always_comb begin
    data0_d = data0_q;
    data1_d = data1_q;
    last0_d = last0_q;
    last1_d = last1_q;
    occ_d   = occ_q;
    unique case ({push_i, do_pop})
      2'b01: begin
        data0_d = data1_q;
        last0_d = last1_q;
        occ_d   = occ_q - 2'd1;
      end
      2'b10: begin
        if (occ_q == 2'd0) begin
          data0_d = push_data_i;
          last0_d = push_last_i;
        end else begin
          data1_d = push_data_i;
          last1_d = push_last_i;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          data0_d = push_data_i;
          last0_d = push_last_i;
        end else begin
          data0_d = data1_q;
          last0_d = last1_q;
          data1_d = push_data_i;
          last1_d = push_last_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data0_q <= '0;
      data1_q <= '0;
      last0_q <= 1'b0;
      last1_q <= 1'b0;
      occ_q   <= '0;
    end else begin
      data0_q <= data0_d;
      data1_q <= data1_d;
      last0_q <= last0_d;
      last1_q <= last1_d;
      occ_q   <= occ_d;
      if (push_i && !do_pop)
        assert (occ_q != 2'd2) else $error("bdy_out_fifo2: push into full FIFO");
    end
  end

  assign data_o  = data0_q;
  assign last_o  = last0_q;
  assign valid_o = (occ_q != 2'd0);
  assign occ_o   = occ_q;

endmodule

// File: rtl/bdy_axis_out_packer.sv
// Output packer: reads coefficient pairs from the dual-bank RAM and streams
// them as 64-bit AXI4-Stream beats {ODD, EVEN}.
//   iSYS_CLK, iSYS_RST     : clock, synchronous active-low reset
//   iSTART, iLEN           : start pulse and beat count (0 gives an empty transfer)
//   oBUSY, oDONE           : transfer in progress / one-cycle completion pulse
//   oRAM_EN, oRAM_ADDR     : RAM read port, data returns one cycle later
//   iRAM_DATA_EVEN/ODD     : coefficient 2k / 2k+1
//   oM_AXIS_*              : AXIS master, TLAST on the final beat
module bdy_axis_out_packer
  import pkg_bdy::*;
(
  input  logic                  iSYS_CLK,
  input  logic                  iSYS_RST,
  input  logic                  iSTART,
  input  logic [PRM_ADDR:0]     iLEN,
  output logic                  oBUSY,
  output logic                  oDONE,
  output logic                  oRAM_EN,
  output logic [PRM_ADDR-1:0]   oRAM_ADDR,
  input  logic [PRM_DRAM-1:0]   iRAM_DATA_EVEN,
  input  logic [PRM_DRAM-1:0]   iRAM_DATA_ODD,
  output logic                  oM_AXIS_TVALID,
  input  logic                  iM_AXIS_TREADY,
  output logic [PRM_DAXI-1:0]   oM_AXIS_TDATA,
  output logic [PRM_DAXI/8-1:0] oM_AXIS_TKEEP,
  output logic                  oM_AXIS_TLAST
);

  localparam logic [PRM_ADDR:0]   LEN_ONE  = 1;
  localparam logic [PRM_ADDR-1:0] ADDR_ONE = 1;

  state_e              state_q, state_d;
  logic [PRM_ADDR:0]   len_q, len_d;
  logic [PRM_ADDR-1:0] rd_addr_q, rd_addr_d;
  logic                inflight_q, inflight_d;
  logic                last_pend_q, last_pend_d;

  logic                issue;
  logic                pop;
  logic                is_last_addr;
  logic [2:0]          pending;
  logic [1:0]          occ;
  logic                fifo_valid;
  logic                fifo_last;
  logic [PRM_DAXI-1:0] fifo_data;

  assign pop          = fifo_valid & iM_AXIS_TREADY;
  // Entries that will occupy the FIFO next cycle if nothing new is issued;
  // keeping this below 2 is what makes overflow impossible.
  assign pending      = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
  assign is_last_addr = ({1'b0, rd_addr_q} == (len_q - LEN_ONE));

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    rd_addr_d   = rd_addr_q;
    inflight_d  = 1'b0;
    last_pend_d = last_pend_q;
    issue       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (iSTART) begin
          if (iLEN == '0) begin
            state_d = ST_DONE;
          end else begin
            len_d     = iLEN;
            rd_addr_d = '0;
            state_d   = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (pending < 3'd2) begin
          issue       = 1'b1;
          inflight_d  = 1'b1;
          last_pend_d = is_last_addr;
          rd_addr_d   = rd_addr_q + ADDR_ONE;
          if (is_last_addr)
            state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Nothing issues here, so empty with nothing in flight means the
        // last beat has already been handed over.
        if ((occ == 2'd0) && !inflight_q)
          state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iSYS_CLK) begin
    if (!iSYS_RST) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      rd_addr_q   <= '0;
      inflight_q  <= 1'b0;
      last_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      rd_addr_q   <= rd_addr_d;
      inflight_q  <= inflight_d;
      last_pend_q <= last_pend_d;
    end
  end

  bdy_out_fifo2 #(
    .DW (PRM_DAXI)
  ) u_fifo (
    .clk_i       (iSYS_CLK),
    .rst_ni      (iSYS_RST),
    .push_i      (inflight_q),
    .push_data_i ({iRAM_DATA_ODD, iRAM_DATA_EVEN}),
    .push_last_i (last_pend_q),
    .pop_i       (pop),
    .data_o      (fifo_data),
    .last_o      (fifo_last),
    .valid_o     (fifo_valid),
    .occ_o       (occ)
  );

  assign oBUSY          = (state_q != ST_IDLE);
  assign oDONE          = (state_q == ST_DONE);
  assign oRAM_EN        = issue;
  assign oRAM_ADDR      = rd_addr_q;
  assign oM_AXIS_TVALID = fifo_valid;
  assign oM_AXIS_TDATA  = fifo_data;
  assign oM_AXIS_TLAST  = fifo_last;
  assign oM_AXIS_TKEEP  = KEEP_ALL;

endmodule

// File: tb/tb_bdy_axis_out_packer.sv
// Bench for bdy_axis_out_packer: RAM model, per-cycle stream/read checker
// and directed scenarios.
module tb_bdy_axis_out_packer;
  import pkg_bdy::*;

  localparam int unsigned AW = PRM_ADDR;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW:0]   len;
  logic          busy, done, ram_en;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_even, ram_odd;
  logic          tvalid, tready, tlast;
  logic [63:0]   tdata;
  logic [7:0]    tkeep;

  always #5 clk = ~clk;

  bdy_axis_out_packer dut (
    .iSYS_CLK       (clk),
    .iSYS_RST       (rst_n),
    .iSTART         (start),
    .iLEN           (len),
    .oBUSY          (busy),
    .oDONE          (done),
    .oRAM_EN        (ram_en),
    .oRAM_ADDR      (ram_addr),
    .iRAM_DATA_EVEN (ram_even),
    .iRAM_DATA_ODD  (ram_odd),
    .oM_AXIS_TVALID (tvalid),
    .iM_AXIS_TREADY (tready),
    .oM_AXIS_TDATA  (tdata),
    .oM_AXIS_TKEEP  (tkeep),
    .oM_AXIS_TLAST  (tlast)
  );

  // Coefficient contents per address; pat=1 gives EVEN=ODD=addr+1.
  bit pat;
  function automatic logic [31:0] even_of(input int unsigned k);
    return 32'(k + 1);
  endfunction
  function automatic logic [31:0] odd_of(input bit p, input int unsigned k);
    return p ? 32'(k + 1) : (32'(k * 3) ^ 32'hA5A5_0000);
  endfunction

  // RAM with one-cycle read latency; garbage when not read so a wrongly
  // timed capture shows up.
  always @(posedge clk) begin
    if (ram_en) begin
      ram_even <= even_of(32'(ram_addr));
      ram_odd  <= odd_of(pat, 32'(ram_addr));
    end else begin
      ram_even <= 32'hBAD0_BAD0;
      ram_odd  <= 32'hBAD1_BAD1;
    end
  end

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transfer model: beat k of a transfer reads address k and must carry
  // {odd(k), even(k)}, TLAST only on k=len-1, oDONE two edges after the
  // final handshake, at most two beats read but not yet delivered.
  int unsigned exp_len = 0, exp_idx = 0, rd_idx = 0;
  bit          active = 0, allow_done = 0, prev_stall = 0;
  int          due = 0;
  logic [63:0] prev_data;
  logic        prev_last;

  always @(negedge clk) begin
    bit hs_last;
    hs_last = 0;
    if (!rst_n) begin
      active     = 0;
      due        = 0;
      prev_stall = 0;
    end else begin
      check("tkeep", 64'(tkeep), 64'hFF);
      if (prev_stall) begin
        check("stall_valid", 64'(tvalid), 64'd1);
        check("stall_data", tdata, prev_data);
        check("stall_last", 64'(tlast), 64'(prev_last));
      end
      if (tvalid && !active)
        check("valid_outside_xfer", 64'(tvalid), 64'd0);
      if (tvalid && tready && active) begin
        check("beat_data", tdata, {odd_of(pat, exp_idx), even_of(exp_idx)});
        check("beat_last", 64'(tlast), 64'(exp_idx == exp_len - 1));
        hs_last = (exp_idx == exp_len - 1);
        exp_idx++;
        if (hs_last) active = 0;
      end
      if (ram_en) begin
        check("rd_in_range", 64'(active && (rd_idx < exp_len)), 64'd1);
        check("rd_addr", 64'(ram_addr), 64'(rd_idx[AW-1:0]));
        rd_idx++;
        check("outstanding_le2", 64'((rd_idx - exp_idx) <= 2), 64'd1);
      end
      if (due != 0)
        check("done_timing", 64'(done), 64'(due == 1));
      else if (done && !allow_done)
        check("done_spurious", 64'(done), 64'd0);
      if (due != 0) due--;
      if (hs_last) due = 2;
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input int unsigned n);
    exp_len = n;
    exp_idx = 0;
    rd_idx  = 0;
    active  = (n != 0);
    start   = 1'b1;
    len     = n[AW:0];
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_done(input int unsigned budget);
    int unsigned c;
    c = 0;
    while ((busy || active || due != 0) && c < budget) begin
      tick();
      c++;
    end
    if (c >= budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_done: transfer still open after %0d cycles", budget);
    end
    check("beat_count", 64'(exp_idx), 64'(exp_len));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned c;
    rst_n  = 1'b0;
    start  = 1'b0;
    len    = '0;
    tready = 1'b0;
    pat    = 1'b1;
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ram_en", 64'(ram_en), 64'd0);
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_tdata", tdata, 64'd0);
    check("rst_tkeep", 64'(tkeep), 64'hFF);
    rst_n = 1'b1;
    tick();

    // Full-length transfer, ready throughout, with latency pins.
    pat    = 1'b1;
    tready = 1'b1;
    start_xfer(4096);
    check("lat_ram_en_n1", 64'(ram_en), 64'd1);
    check("lat_busy_n1", 64'(busy), 64'd1);
    check("lat_tvalid_n1", 64'(tvalid), 64'd0);
    tick();
    check("lat_tvalid_n2", 64'(tvalid), 64'd0);
    tick();
    check("lat_tvalid_n3", 64'(tvalid), 64'd1);
    check("first_beat", tdata, 64'h0000_0001_0000_0001);
    c = 0;
    while (exp_idx < 4096 && c < 5000) begin
      check("no_bubble", 64'(tvalid), 64'd1);
      tick();
      c++;
    end
    wait_done(100);
    tick();

    // Stall for 10 cycles from beat 5.
    pat = 1'b0;
    start_xfer(16);
    c = 0;
    while (exp_idx < 5 && c < 100) begin
      tick();
      c++;
    end
    tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i >= 3) check("stall_no_read", 64'(ram_en), 64'd0);
      tick();
    end
    tready = 1'b1;
    wait_done(200);
    tick();

    // Random backpressure.
    start_xfer(64);
    c = 0;
    while (active && c < 2000) begin
      tready = 1'($urandom_range(0, 1));
      tick();
      c++;
    end
    tready = 1'b1;
    wait_done(200);
    tick();

    // Single beat: busy for exactly five cycles.
    start_xfer(1);
    c = 0;
    while (busy && c < 20) begin
      c++;
      if (c == 3) begin
        check("one_beat_data", tdata, 64'hA5A5_0000_0000_0001);
        check("one_beat_last", 64'(tlast), 64'd1);
      end
      if (c == 5) check("one_beat_done", 64'(done), 64'd1);
      tick();
    end
    check("one_beat_busy_cycles", 64'(c), 64'd5);
    wait_done(50);
    tick();

    // Restart pulse while running is ignored.
    start_xfer(32);
    repeat (10) tick();
    start = 1'b1;
    len   = 13'd2;
    tick();
    start = 1'b0;
    wait_done(200);
    check("restart_total_beats", 64'(exp_idx), 64'd32);
    tick();

    // Zero length: done without any beat.
    allow_done = 1;
    start_xfer(0);
    check("zero_done", 64'(done), 64'd1);
    check("zero_busy", 64'(busy), 64'd1);
    check("zero_tvalid", 64'(tvalid), 64'd0);
    tick();
    check("zero_done_clear", 64'(done), 64'd0);
    check("zero_busy_clear", 64'(busy), 64'd0);
    allow_done = 0;
    tick();

    // Reset mid-transfer, then a fresh short transfer.
    pat = 1'b1;
    start_xfer(4096);
    c = 0;
    while (exp_idx < 100 && c < 500) begin
      tick();
      c++;
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_ram_en", 64'(ram_en), 64'd0);
    check("abort_ram_addr", 64'(ram_addr), 64'd0);
    check("abort_tvalid", 64'(tvalid), 64'd0);
    check("abort_tdata", tdata, 64'd0);
    check("abort_tlast", 64'(tlast), 64'd0);
    repeat (5) begin
      check("abort_quiet", 64'(tvalid | done | busy), 64'd0);
      tick();
    end
    start_xfer(8);
    wait_done(100);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
